// File: rtl/writeback.sv
// Stage 5 of the RV32I pipeline: retires MEMORY-stage results, completes loads
// (wait for ack, align, extend), drives the rd write port and counts instret.
module writeback #(
  parameter int OPCODE_WIDTH = 11,
  parameter int LOAD_IDX     = 0,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memory_valid,
  input  logic [2:0]              memory_funct3,
  input  logic [OPCODE_WIDTH-1:0] memory_opcode_type,
  input  logic                    memory_rd_wr_en,
  input  logic [4:0]              memory_rd,
  input  logic [31:0]             memory_rd_wr_data,
  input  logic [31:0]             dmem_rdata,
  input  logic                    dmem_ack,
  input  logic                    clk_en,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    writeback_rd_wr_en,
  output logic [4:0]              writeback_rd,
  output logic [31:0]             writeback_rd_wr_data,
  output logic                    next_stall,
  output logic                    load_fault,
  output logic [63:0]             instret
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [TW-1:0] r_timeout;
  logic [TW-1:0] w_timeoutNext;

  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr;
  logic        r_rdWrEn;

  logic        w_accept;
  logic        w_take;
  logic        w_isLoad;
  logic        w_misaligned;
  logic        w_doWrite;
  logic        w_loadDone;
  logic        w_latchLoad;
  logic        w_fault;
  logic        w_retire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic        w_unused;

  assign w_unused = ^memory_opcode_type;

  assign next_stall = (r_state == S_WAIT_ACK) & ~dmem_ack;
  assign w_accept   = clk_en & ~stall & ~next_stall;
  assign w_take     = w_accept & memory_valid & ~flush;
  assign w_isLoad   = memory_opcode_type[LOAD_IDX];

  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
  always_comb begin
    w_misaligned = 1'b0;
    case (memory_funct3[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = memory_rd_wr_data[0];
      default: w_misaligned = (memory_rd_wr_data[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_byte     = dmem_rdata[{r_addr, 3'b000} +: 8];
    w_half     = dmem_rdata[{r_addr[1], 4'b0000} +: 16];
    w_loadData = dmem_rdata;
    case (r_funct3[1:0])
      2'b00:   w_loadData = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_loadData = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

  // Flush beats a same-cycle ack; an ack beats a same-cycle timeout.
  always_comb begin
    w_nextState   = r_state;
    w_timeoutNext = r_timeout;
    w_doWrite     = 1'b0;
    w_loadDone    = 1'b0;
    w_latchLoad   = 1'b0;
    w_fault       = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_retire = 1'b1;
          if (!w_isLoad) begin
            w_doWrite = 1'b1;
          end else if (w_misaligned) begin
            w_fault = 1'b1;
          end else begin
            w_retire      = 1'b0;
            w_latchLoad   = 1'b1;
            w_nextState   = S_WAIT_ACK;
            w_timeoutNext = '0;
          end
        end
      end
      S_WAIT_ACK: begin
        if (flush) begin
          w_nextState   = S_IDLE;
          w_timeoutNext = '0;
        end else if (dmem_ack) begin
          w_loadDone    = 1'b1;
          w_retire      = 1'b1;
          w_nextState   = S_IDLE;
          w_timeoutNext = '0;
        end else if (r_timeout == TIMEOUT_LAST) begin
          w_fault       = 1'b1;
          w_retire      = 1'b1;
          w_nextState   = S_IDLE;
          w_timeoutNext = '0;
        end else begin
          w_timeoutNext = r_timeout + 1'b1;
        end
      end
      default: begin
        w_nextState   = S_IDLE;
        w_timeoutNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state              <= S_IDLE;
      r_timeout            <= '0;
      r_rd                 <= '0;
      r_funct3             <= '0;
      r_addr               <= '0;
      r_rdWrEn             <= 1'b0;
      writeback_rd_wr_en   <= 1'b0;
      writeback_rd         <= '0;
      writeback_rd_wr_data <= '0;
      load_fault           <= 1'b0;
      instret              <= '0;
    end else begin
      r_state            <= w_nextState;
      r_timeout          <= w_timeoutNext;
      load_fault         <= w_fault;
      writeback_rd_wr_en <= 1'b0;
      if (w_retire) begin
        instret <= instret + 64'd1;
      end
      if (w_latchLoad) begin
        r_rd     <= memory_rd;
        r_funct3 <= memory_funct3;
        r_addr   <= memory_rd_wr_data[1:0];
        r_rdWrEn <= memory_rd_wr_en;
      end
      if (w_doWrite) begin
        writeback_rd_wr_en   <= memory_rd_wr_en & (memory_rd != 5'd0);
        writeback_rd         <= memory_rd;
        writeback_rd_wr_data <= memory_rd_wr_data;
      end else if (w_loadDone) begin
        writeback_rd_wr_en   <= r_rdWrEn & (r_rd != 5'd0);
        writeback_rd         <= r_rd;
        writeback_rd_wr_data <= w_loadData;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: ALU retire, load alignment/extension, stalls,
// misalignment and timeout faults, flush and asynchronous reset.
module tb_writeback;

   logic        clk;
   logic        rst;
   logic        memory_valid;
   logic [2:0]  memory_funct3;
   logic [10:0] memory_opcode_type;
   logic        memory_rd_wr_en;
   logic [4:0]  memory_rd;
   logic [31:0] memory_rd_wr_data;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        clk_en;
   logic        stall;
   logic        flush;
   logic        writeback_rd_wr_en;
   logic [4:0]  writeback_rd;
   logic [31:0] writeback_rd_wr_data;
   logic        next_stall;
   logic        load_fault;
   logic [63:0] instret;

   int errorCount;
   int checkCount;

   writeback dut (
      .clk                  (clk),
      .rst                  (rst),
      .memory_valid         (memory_valid),
      .memory_funct3        (memory_funct3),
      .memory_opcode_type   (memory_opcode_type),
      .memory_rd_wr_en      (memory_rd_wr_en),
      .memory_rd            (memory_rd),
      .memory_rd_wr_data    (memory_rd_wr_data),
      .dmem_rdata           (dmem_rdata),
      .dmem_ack             (dmem_ack),
      .clk_en               (clk_en),
      .stall                (stall),
      .flush                (flush),
      .writeback_rd_wr_en   (writeback_rd_wr_en),
      .writeback_rd         (writeback_rd),
      .writeback_rd_wr_data (writeback_rd_wr_data),
      .next_stall           (next_stall),
      .load_fault           (load_fault),
      .instret              (instret)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one instruction from MEMORY with clk_en high.
   task automatic applyStimulus(input logic isLoad, input logic [2:0] funct3, input logic [4:0] rd,
                                input logic rdWrEn, input logic [31:0] data);
      memory_valid       = 1'b1;
      memory_opcode_type = isLoad ? 11'b000_0000_0001 : 11'b000_0000_0010;
      memory_funct3      = funct3;
      memory_rd          = rd;
      memory_rd_wr_en    = rdWrEn;
      memory_rd_wr_data  = data;
      clk_en             = 1'b1;
   endtask

   // Advances one clock and settles just after the edge; clk_en is single-cycle.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      clk_en = 1'b0;
   endtask

   task automatic checkWrite(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] data);
      checkOutput({tag, "_en"}, {63'd0, writeback_rd_wr_en}, {63'd0, en});
      if (en) begin
         checkOutput({tag, "_rd"}, {59'd0, writeback_rd}, {59'd0, rd});
         checkOutput({tag, "_data"}, {32'd0, writeback_rd_wr_data}, {32'd0, data});
      end
   endtask

   // Main directed sequence; expected values are hand-computed per vector.
   initial begin
      errorCount         = 0;
      checkCount         = 0;
      rst                = 1'b1;
      memory_valid       = 1'b0;
      memory_funct3      = 3'd0;
      memory_opcode_type = '0;
      memory_rd_wr_en    = 1'b0;
      memory_rd          = 5'd0;
      memory_rd_wr_data  = 32'd0;
      dmem_rdata         = 32'd0;
      dmem_ack           = 1'b0;
      clk_en             = 1'b0;
      stall              = 1'b0;
      flush              = 1'b0;

      #2 rst = 1'b0;
      #1;
      checkOutput("reset_wr_en", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("reset_rd", {59'd0, writeback_rd}, 64'd0);
      checkOutput("reset_data", {32'd0, writeback_rd_wr_data}, 64'd0);
      checkOutput("reset_stall", {63'd0, next_stall}, 64'd0);
      checkOutput("reset_fault", {63'd0, load_fault}, 64'd0);
      checkOutput("reset_instret", instret, 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      applyStimulus(1'b0, 3'b000, 5'd5, 1'b1, 32'h0000_1234);
      stepCycle();
      checkWrite("add", 1'b1, 5'd5, 32'h0000_1234);
      checkOutput("add_instret", instret, 64'd1);
      memory_valid = 1'b0;
      stepCycle();
      checkOutput("add_pulse", {63'd0, writeback_rd_wr_en}, 64'd0);

      applyStimulus(1'b1, 3'b000, 5'd7, 1'b1, 32'h0000_1003);
      stepCycle();
      checkOutput("lb_stall1", {63'd0, next_stall}, 64'd1);
      checkOutput("lb_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      stepCycle();
      checkOutput("lb_stall2", {63'd0, next_stall}, 64'd1);
      dmem_rdata = 32'h80FF_0011;
      dmem_ack   = 1'b1;
      #1;
      checkOutput("lb_stall_ack", {63'd0, next_stall}, 64'd0);
      stepCycle();
      dmem_ack = 1'b0;
      checkWrite("lb", 1'b1, 5'd7, 32'hFFFF_FF80);
      checkOutput("lb_instret", instret, 64'd2);

      applyStimulus(1'b1, 3'b101, 5'd8, 1'b1, 32'h0000_2002);
      stepCycle();
      dmem_rdata = 32'hBEEF_1234;
      dmem_ack   = 1'b1;
      #1;
      checkOutput("lhu_nostall", {63'd0, next_stall}, 64'd0);
      stepCycle();
      dmem_ack = 1'b0;
      checkWrite("lhu", 1'b1, 5'd8, 32'h0000_BEEF);
      checkOutput("lhu_instret", instret, 64'd3);

      applyStimulus(1'b1, 3'b010, 5'd9, 1'b1, 32'h0000_3001);
      stepCycle();
      checkOutput("lwmis_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("lwmis_fault", {63'd0, load_fault}, 64'd1);
      checkOutput("lwmis_idle", {63'd0, next_stall}, 64'd0);
      checkOutput("lwmis_instret", instret, 64'd4);
      memory_valid = 1'b0;
      stepCycle();
      checkOutput("lwmis_pulse", {63'd0, load_fault}, 64'd0);

      applyStimulus(1'b1, 3'b010, 5'd10, 1'b1, 32'h0000_4000);
      stepCycle();
      checkOutput("to_stall_first", {63'd0, next_stall}, 64'd1);
      repeat (14) stepCycle();
      checkOutput("to_stall_last", {63'd0, next_stall}, 64'd1);
      checkOutput("to_nofault_early", {63'd0, load_fault}, 64'd0);
      stepCycle();
      checkOutput("to_fault", {63'd0, load_fault}, 64'd1);
      checkOutput("to_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("to_released", {63'd0, next_stall}, 64'd0);
      checkOutput("to_instret", instret, 64'd5);
      dmem_rdata = 32'hDEAD_BEEF;
      dmem_ack   = 1'b1;
      stepCycle();
      dmem_ack = 1'b0;
      checkOutput("stray_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("stray_instret", instret, 64'd5);

      applyStimulus(1'b0, 3'b000, 5'd12, 1'b1, 32'h0000_0055);
      stall = 1'b1;
      stepCycle();
      stall = 1'b0;
      checkOutput("stall_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("stall_instret", instret, 64'd5);

      applyStimulus(1'b0, 3'b000, 5'd12, 1'b1, 32'h0000_0055);
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      checkOutput("flushacc_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("flushacc_instret", instret, 64'd5);

      applyStimulus(1'b0, 3'b000, 5'd0, 1'b1, 32'h0000_00AA);
      stepCycle();
      checkOutput("x0_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("x0_instret", instret, 64'd6);

      applyStimulus(1'b1, 3'b010, 5'd11, 1'b1, 32'h0000_5000);
      stepCycle();
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      checkOutput("flushwait_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("flushwait_idle", {63'd0, next_stall}, 64'd0);
      checkOutput("flushwait_instret", instret, 64'd6);
      dmem_ack = 1'b1;
      stepCycle();
      dmem_ack = 1'b0;
      checkOutput("flushwait_stray", {63'd0, writeback_rd_wr_en}, 64'd0);

      applyStimulus(1'b1, 3'b001, 5'd13, 1'b1, 32'h0000_6002);
      stepCycle();
      dmem_rdata = 32'h8001_0000;
      dmem_ack   = 1'b1;
      stepCycle();
      dmem_ack = 1'b0;
      checkWrite("lh", 1'b1, 5'd13, 32'hFFFF_8001);
      checkOutput("lh_instret", instret, 64'd7);

      applyStimulus(1'b1, 3'b010, 5'd14, 1'b1, 32'h0000_7000);
      stepCycle();
      checkOutput("rstwait_stall", {63'd0, next_stall}, 64'd1);
      #3 rst = 1'b0;
      #1;
      checkOutput("rstwait_stall0", {63'd0, next_stall}, 64'd0);
      checkOutput("rstwait_wr_en", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("rstwait_rd", {59'd0, writeback_rd}, 64'd0);
      checkOutput("rstwait_data", {32'd0, writeback_rd_wr_data}, 64'd0);
      checkOutput("rstwait_instret", instret, 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      dmem_ack = 1'b1;
      stepCycle();
      dmem_ack = 1'b0;
      checkOutput("idleack_nowrite", {63'd0, writeback_rd_wr_en}, 64'd0);
      checkOutput("idleack_instret", instret, 64'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
